// File: rtl/vga_rx_if.sv
// Video receive bundle: sampled sync/colour from the source, recovered
// position and qualified pixel stream back out of the timing checker.
interface vga_rx_if;
   logic        p_tick;
   logic        hsync_in;
   logic        vsync_in;
   logic [11:0] rgb_in;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [11:0] rgb_out;
   logic        pixel_valid;
   logic        line_start;
   logic        frame_start;
   logic        locked;
   logic        h_err;
   logic        v_err;

   modport master (
      output p_tick, hsync_in, vsync_in, rgb_in,
      input  pixel_x, pixel_y, rgb_out, pixel_valid, line_start, frame_start,
             locked, h_err, v_err
   );

   modport slave (
      input  p_tick, hsync_in, vsync_in, rgb_in,
      output pixel_x, pixel_y, rgb_out, pixel_valid, line_start, frame_start,
             locked, h_err, v_err
   );
endinterface

// File: rtl/vga_rx_timing.sv
// VGA receive timing recovery: tracks x/y from sync edges, flags line/frame
// timing errors, runs a lock FSM and emits a qualified pixel stream.
module vga_rx_timing #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_TOTAL     = 800,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_TOTAL     = 525,
   parameter logic SYNC_POL    = 1'b1,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic    clk,
   input  logic    reset,
   vga_rx_if.slave vif
);

   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
   // An impossible timing setup can never reach LOCKED.
   localparam bit CFG_OK = (H_ACTIVE + H_FP + H_SYNC <= H_TOTAL) &&
                           (V_ACTIVE + V_FP + V_SYNC <= V_TOTAL) &&
                           (H_TOTAL <= 1024) && (V_TOTAL <= 1024) &&
                           (LOCK_FRAMES >= 1) && (LOCK_FRAMES <= 15);

   typedef enum logic [1:0] {UNLOCKED, HALIGN, ACQUIRE, LOCKED} state_t;

   state_t      state, state_d;
   logic [3:0]  good_cnt, cnt_d, cnt_inc;
   logic [9:0]  h, v, h_pred, v_pred, h_nxt, v_nxt;
   logic        prev_hs, prev_vs, primed;
   logic        adv, hs_edge, vs_edge, h_err_c, v_err_c, pix_ok;
   logic [11:0] rgb_q;
   logic        valid_q, line_q, frame_q, h_err_q, v_err_q;

   always_comb begin
      adv     = vif.p_tick && primed;
      h_pred  = (h == H_LAST) ? 10'd0 : h + 10'd1;
      v_pred  = v;
      if (h == H_LAST)
         v_pred = (v == V_LAST) ? 10'd0 : v + 10'd1;
      hs_edge = (prev_hs != SYNC_POL) && (vif.hsync_in == SYNC_POL);
      vs_edge = (prev_vs != SYNC_POL) && (vif.vsync_in == SYNC_POL);

      // An early/late edge or a missing pulse at the predicted spot are both errors.
      h_err_c = adv && (state != UNLOCKED) &&
                (hs_edge ? (h_pred != HS_START) : (h_pred == HS_START));
      if (vs_edge)
         v_err_c = adv && ((state == ACQUIRE) || (state == LOCKED)) &&
                   ((v_pred != VS_START) || (h_pred != 10'd0));
      else
         v_err_c = adv && (state == LOCKED) && (h_pred == 10'd0) && (v_pred == VS_START);

      h_nxt   = vs_edge ? 10'd0 : (hs_edge ? HS_START : h_pred);
      v_nxt   = vs_edge ? VS_START : v_pred;
      pix_ok  = (state == LOCKED) && (h_nxt < H_ACT) && (v_nxt < V_ACT);
      cnt_inc = good_cnt + 4'd1;
   end

   always_comb begin
      state_d = state;
      cnt_d   = good_cnt;
      if (adv) begin
         case (state)
            UNLOCKED: if (hs_edge) state_d = HALIGN;
            HALIGN: begin
               if (h_err_c)
                  state_d = UNLOCKED;
               else if (vs_edge) begin
                  state_d = ACQUIRE;
                  cnt_d   = 4'd0;
               end
            end
            ACQUIRE: begin
               if (h_err_c || v_err_c) begin
                  state_d = UNLOCKED;
                  cnt_d   = 4'd0;
               end else if (vs_edge) begin
                  if (cnt_inc == LOCK_N) begin
                     state_d = CFG_OK ? LOCKED : ACQUIRE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            LOCKED: if (h_err_c || v_err_c) state_d = UNLOCKED;
            default: state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= UNLOCKED;
         good_cnt <= 4'd0;
      end else begin
         state    <= state_d;
         good_cnt <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h       <= 10'd0;
         v       <= 10'd0;
         prev_hs <= 1'b0;
         prev_vs <= 1'b0;
         primed  <= 1'b0;
         rgb_q   <= 12'd0;
         valid_q <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         h_err_q <= 1'b0;
         v_err_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         h_err_q <= h_err_c;
         v_err_q <= v_err_c;
         if (vif.p_tick) begin
            // The priming tick only captures sync history, so a held sync is not an edge.
            prev_hs <= vif.hsync_in;
            prev_vs <= vif.vsync_in;
            primed  <= 1'b1;
            if (primed) begin
               h       <= h_nxt;
               v       <= v_nxt;
               rgb_q   <= vif.rgb_in;
               valid_q <= pix_ok;
               line_q  <= pix_ok && (h_nxt == 10'd0);
               frame_q <= pix_ok && (h_nxt == 10'd0) && (v_nxt == 10'd0);
            end
         end
      end
   end

   assign vif.pixel_x     = h;
   assign vif.pixel_y     = v;
   assign vif.rgb_out     = rgb_q;
   assign vif.pixel_valid = valid_q;
   assign vif.line_start  = line_q;
   assign vif.frame_start = frame_q;
   assign vif.locked      = (state == LOCKED);
   assign vif.h_err       = h_err_q;
   assign vif.v_err       = v_err_q;

endmodule
